// File: rtl/vec_eval_pkg.sv
// Shared types for the vector evaluation pipeline.
// Holds the mode encodings, the FSM state enum and a ceiling-divide helper
// that is used to derive the beat count from the vector and bus widths.
package vec_eval_pkg;

    // Evaluation mode encodings
    typedef enum logic [1:0] {
        MODE_XOR = 2'b00,
        MODE_OR  = 2'b01,
        MODE_AND = 2'b10,
        MODE_BYP = 2'b11
    } mode_e;

    // Pipeline control states
    typedef enum logic [1:0] {
        ST_LOAD = 2'b00,
        ST_EVAL = 2'b01,
        ST_HOLD = 2'b10
    } state_e;

    function automatic int unsigned ceil_div(input int unsigned a, input int unsigned b);
        return (a + b - 1) / b;
    endfunction

endpackage

// File: rtl/fold_core.sv
// Purely combinational fold/bypass datapath.
// Ports:
//   vec    : IN_W-bit assembled stimulus vector
//   mode   : evaluation mode (XOR/OR/AND fold, or bypass)
//   fold_c : OUT_W-bit result; fold bit j combines every vec[i] with i mod OUT_W == j
module fold_core
    import vec_eval_pkg::*;
#(
    parameter int unsigned IN_W  = 150,
    parameter int unsigned OUT_W = 80
) (
    input  logic [IN_W-1:0]  vec,
    input  logic [1:0]       mode,
    output logic [OUT_W-1:0] fold_c
);

    logic [OUT_W-1:0] xor_v;
    logic [OUT_W-1:0] or_v;
    logic [OUT_W-1:0] and_v;

    // Every input bit folds into output lane i mod OUT_W
    always_comb begin
        xor_v = '0;
        or_v  = '0;
        and_v = '1;
        for (int unsigned i = 0; i < IN_W; i++) begin
            xor_v[i % OUT_W] = xor_v[i % OUT_W] ^ vec[i];
            or_v[i % OUT_W]  = or_v[i % OUT_W]  | vec[i];
            and_v[i % OUT_W] = and_v[i % OUT_W] & vec[i];
        end
    end

    // Mode select
    always_comb begin
        fold_c = '0;
        unique case (mode_e'(mode))
            MODE_XOR: fold_c = xor_v;
            MODE_OR:  fold_c = or_v;
            MODE_AND: fold_c = and_v;
            MODE_BYP: fold_c = vec[OUT_W-1:0];
            default:  fold_c = '0;
        endcase
    end

endmodule

// File: rtl/vec_eval_pipe.sv
// Beat-assembling vector evaluator.
// Collects NBEATS = ceil(IN_W/BUS_W) beats into a vector, folds it down to
// OUT_W bits according to the mode captured on beat 0, and holds the result
// until the downstream handshake. Badly framed vectors are dropped with a
// one-cycle err pulse.
// Ports:
//   clk, rst                  : clock, synchronous active-high reset
//   s_valid/s_ready/s_data/s_last : input beat stream
//   mode                      : evaluation mode, sampled on beat 0
//   m_valid/m_ready/m_data    : result handshake
//   err                       : framing error pulse
module vec_eval_pipe
    import vec_eval_pkg::*;
#(
    parameter int unsigned IN_W  = 150,
    parameter int unsigned OUT_W = 80,
    parameter int unsigned BUS_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [BUS_W-1:0] s_data,
    input  logic             s_last,
    input  logic [1:0]       mode,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [OUT_W-1:0] m_data,
    output logic             err
);

    localparam int unsigned NBEATS = ceil_div(IN_W, BUS_W);
    localparam int unsigned CNT_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NBEATS - 1);

    state_e           state_q,   state_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic [IN_W-1:0]  vec_q,     vec_d;
    mode_e            mode_q,    mode_d;
    logic [OUT_W-1:0] m_data_q,  m_data_d;
    logic             m_valid_q, m_valid_d;
    logic             s_ready_q, s_ready_d;
    logic             err_q,     err_d;

    logic             beat_acc;
    logic             frame_err;
    logic [IN_W-1:0]  vec_base;
    logic [OUT_W-1:0] fold_res;

    fold_core #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_fold_core (
        .vec    (vec_q),
        .mode   (mode_q),
        .fold_c (fold_res)
    );

    // Next-state and datapath updates
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        vec_d     = vec_q;
        mode_d    = mode_q;
        m_data_d  = m_data_q;
        err_d     = 1'b0;
        vec_base  = vec_q;
        frame_err = 1'b0;
        // s_ready_q is high exactly while in LOAD
        beat_acc  = s_valid && s_ready_q;

        unique case (state_q)
            ST_LOAD: begin
                if (beat_acc) begin
                    frame_err = (s_last != (cnt_q == LAST_BEAT));
                    // Beat 0 starts a fresh vector: stale bits cleared, mode captured
                    if (cnt_q == '0) begin
                        vec_base = '0;
                        mode_d   = mode_e'(mode);
                    end
                    vec_d = vec_base;
                    // Bits past IN_W in the final beat have no home and drop out
                    for (int unsigned i = 0; i < IN_W; i++) begin
                        if (cnt_q == CNT_W'(i / BUS_W)) begin
                            vec_d[i] = s_data[i % BUS_W];
                        end
                    end
                    if (frame_err) begin
                        err_d = 1'b1;
                        cnt_d = '0;
                        vec_d = '0;
                    end else if (cnt_q == LAST_BEAT) begin
                        cnt_d   = '0;
                        state_d = ST_EVAL;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_EVAL: begin
                m_data_d = fold_res;
                state_d  = ST_HOLD;
            end
            ST_HOLD: begin
                if (m_ready) begin
                    state_d = ST_LOAD;
                end
            end
            default: begin
                state_d = ST_LOAD;
            end
        endcase

        s_ready_d = (state_d == ST_LOAD);
        m_valid_d = (state_d == ST_HOLD);
    end

    // State registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_LOAD;
            cnt_q     <= '0;
            vec_q     <= '0;
            mode_q    <= MODE_XOR;
            m_data_q  <= '0;
            m_valid_q <= 1'b0;
            s_ready_q <= 1'b1;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            vec_q     <= vec_d;
            mode_q    <= mode_d;
            m_data_q  <= m_data_d;
            m_valid_q <= m_valid_d;
            s_ready_q <= s_ready_d;
            err_q     <= err_d;
        end
    end

    assign s_ready = s_ready_q;
    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;
    assign err     = err_q;

endmodule

// File: doc/vec_eval_pipe.md
VEC_EVAL_PIPE -- requirements
Module: vec_eval_pipe

Interface
REQ-001 SHALL have parameter IN_W, default 150, meaning stimulus vector width in bits.
REQ-002 SHALL have parameter OUT_W, default 80, meaning result vector width in bits; legal range 1..IN_W.
REQ-003 SHALL have parameter BUS_W, default 32, meaning input beat width; NBEATS = ceil(IN_W/BUS_W), derived.
REQ-004 clk  input  1  sole clock; all state changes on rising edge.
REQ-005 rst  input  1  reset; synchronous, active-high.
REQ-006 s_valid  input  1  input beat valid.
REQ-007 s_ready  output  1  block accepts a beat this cycle.
REQ-008 s_data  input  BUS_W  input beat payload.
REQ-009 s_last  input  1  marks final beat of a vector.
REQ-010 mode  input  2  evaluation mode: 00 XOR-fold, 01 OR-fold, 10 AND-fold, 11 bypass.
REQ-011 m_valid  output  1  result valid.
REQ-012 m_ready  input  1  downstream accepts result.
REQ-013 m_data  output  OUT_W  result vector.
REQ-014 err  output  1  one-cycle pulse on framing error.

Function
REQ-015 A beat transfers only when s_valid and s_ready are both 1 on a rising edge.
REQ-016 Beat k (0-based) SHALL write vector bits [k*BUS_W +: BUS_W]; bits at or above IN_W SHALL be discarded.
REQ-017 mode SHALL be sampled on the accepted beat 0 and held for that vector; later mode changes SHALL not affect it.
REQ-018 FSM states LOAD, EVAL, HOLD; LOAD->EVAL on accepted beat NBEATS-1 with s_last=1; EVAL->HOLD unconditionally after one cycle; HOLD->LOAD when m_ready=1.
REQ-019 s_ready SHALL be 1 only in LOAD; m_valid SHALL be 1 only in HOLD.
REQ-020 Fold modes: m_data[j] = op over all vec[i] with i mod OUT_W == j, 0<=i<IN_W; op = XOR, OR or AND per mode.
REQ-021 Bypass mode: m_data = vec[OUT_W-1:0].
REQ-022 m_data SHALL be registered in EVAL and stay stable throughout HOLD.
REQ-023 m_valid SHALL rise exactly two rising edges after the edge accepting the final beat.
REQ-024 Framing error: s_last=1 on a beat k<NBEATS-1, or s_last=0 on beat NBEATS-1 -> err pulses for one cycle after that edge, the partial vector is discarded, the beat counter returns to 0, state stays LOAD, and no result is produced.
REQ-025 Beat counter SHALL wrap to 0 after beat NBEATS-1 and after any error.
REQ-026 Vector register bits not written by the current vector SHALL be cleared at the start of each vector (beat 0 accept).

Reset
REQ-027 rst=1 at a rising edge SHALL force state LOAD, beat counter 0, vector register 0, sampled mode 00, m_data 0, m_valid 0, err 0, s_ready 1 on the next cycle.
REQ-028 Reset asserted mid-load or in HOLD SHALL abandon the in-flight vector with no result and no err pulse.

Structure
REQ-029 Mode encodings and FSM state enum SHALL live in shared package vec_eval_pkg.
REQ-030 The fold/bypass datapath SHALL be a purely combinational sub-module fold_core (params IN_W, OUT_W); vec_eval_pipe holds all sequential logic.

Verification (defaults IN_W=150, OUT_W=80, BUS_W=32, NBEATS=5)
REQ-031 All-ones vector, mode 00, s_last on beat 4 -> m_data = {10 ones, 70 zeros} (bits 79..70 one), m_valid two edges after beat 4 accept.
REQ-032 All-ones vector except bit 0 = 0, mode 10 -> m_data[0]=0, m_data[79:1] all ones; same vector mode 01 -> all ones.
REQ-033 Beat 0 = 32'hDEADBEEF, others 0, mode 11 -> m_data = 80'h0000_0000_0000_DEAD_BEEF.
REQ-034 s_last=1 on beat 2 -> err pulse one cycle, no m_valid, s_ready stays 1; next well-formed vector evaluates correctly with no leftover bits.
REQ-035 m_ready held 0 for 5 cycles in HOLD -> m_valid and m_data stable, s_ready 0; handshake on cycle 6 -> LOAD next cycle.
REQ-036 rst asserted after beat 2 accept -> all outputs at reset values next cycle, no err, no result; subsequent vector correct.
